comp_cic_fir: RTL
=================

COMP_CIC_FIR -- requirements
Module: comp_cic_fir

Interface
REQ-001 SHALL have parameter Win, default 16: input sample width, signed.
REQ-002 SHALL have parameter Wcoef, default 18: coefficient width, signed.
REQ-003 SHALL have parameter Wout, default 16: output sample width, signed.
REQ-004 SHALL have parameter NTAPS, default 16: taps per channel, at least 2.
REQ-005 SHALL have parameter NCH, default 2: independent channels, at least 1.
REQ-006 SHALL have parameter SHIFT, default 17: right shift applied to the accumulator before output.
REQ-007 SHALL have derived widths Waccum = Win+Wcoef+clog2(NTAPS), AW = clog2(NTAPS) and CW = max(1,clog2(NCH)).
REQ-008 SHALL have clk  in  1: single clock; all logic on its rising edge.
REQ-009 SHALL have ic_rst_n  in  1: reset, asynchronous, active-low.
REQ-010 SHALL have id_in  in  Win: input sample.
REQ-011 SHALL have ic_ch  in  CW: channel index of id_in.
REQ-012 SHALL have ic_valid  in  1: sample offered.
REQ-013 SHALL have oc_ready  out  1: block can accept a sample or a coefficient write.
REQ-014 SHALL have ic_coef_we  in  1: coefficient write strobe.
REQ-015 SHALL have ic_coef_addr  in  AW: tap index to write.
REQ-016 SHALL have id_coef  in  Wcoef: coefficient value.
REQ-017 SHALL have od_out  out  Wout: filtered sample.
REQ-018 SHALL have oc_ch  out  CW: channel of od_out.
REQ-019 SHALL have oc_valid  out  1: single-cycle output strobe.
REQ-020 SHALL have oc_sat  out  1: od_out was saturated; qualified by oc_valid.

Function
REQ-021 SHALL accept a sample when ic_valid && oc_ready && ic_ch < NCH; when ic_ch >= NCH, the offer is dropped, no output is produced and the block stays in IDLE.
REQ-022 SHALL keep per channel a circular delay line of NTAPS samples with its own write pointer; an accepted sample overwrites the oldest entry, and the pointer wraps from NTAPS-1 to 0.
REQ-023 SHALL implement FSM IDLE -> MAC -> ROUND -> IDLE: IDLE->MAC on accept; MAC lasts exactly NTAPS cycles (tap counter 0..NTAPS-1); ROUND lasts 1 cycle; ROUND->IDLE unconditionally.
REQ-024 SHALL drive oc_ready high only in IDLE.
REQ-025 SHALL compute, in MAC, acc = sum over k of c[k]*x[n-k], where x[n] is the sample just accepted; the accumulator is cleared on entry to MAC.
REQ-026 SHALL use full-precision arithmetic: products Win+Wcoef bits, accumulator Waccum bits, so the accumulator cannot overflow.
REQ-027 SHALL round in ROUND: add 2^(SHIFT-1) to acc, shift arithmetically right by SHIFT, then saturate to [-2^(Wout-1), 2^(Wout-1)-1]; oc_sat=1 when clipping occurred.
REQ-028 SHALL assert oc_valid for one cycle exactly NTAPS+2 cycles after the accept edge; od_out, oc_ch and oc_sat are held until the next oc_valid.
REQ-029 SHALL apply a coefficient write only when oc_ready=1; ic_coef_we while busy is ignored.
REQ-030 SHALL, when a coefficient write and a sample accept occur in the same IDLE cycle, perform both, and that sample's computation SHALL use the new coefficient.
REQ-031 SHALL share the coefficient set across all channels.
REQ-032 SHALL accept back-to-back samples at a maximum rate of one per NTAPS+2 cycles, with no internal queue.

Reset
REQ-033 SHALL, while ic_rst_n=0, asynchronously force: FSM=IDLE, oc_ready=1 after release, oc_valid=0, od_out=0, oc_ch=0, oc_sat=0, all delay lines=0, pointers=0, coefficients=0, accumulator=0.
REQ-034 SHALL, on reset asserted mid-computation, abandon the computation without producing an oc_valid.

Structure
REQ-035 SHALL place in a shared package comp_cic_pkg: the FSM state enum (IDLE, MAC, ROUND) and the clog2-based width helper.
REQ-036 SHALL instantiate one sub-module, comp_cic_mac_acc: a parametrised signed multiply-accumulate with clear and enable, asynchronous active-low reset, and widths Win/Wcoef/Waccum.

Verification
REQ-037 SHALL cover impulse: coefs c[k]=k+1, ch0 inputs 2^15-1 then zeros, SHIFT=0, Wout=Waccum -> outputs (k+1)*(2^15-1) for k=0..15, then 0.
REQ-038 SHALL cover saturation: all coefs 2^17-1, inputs 2^15-1 for 16 samples, default widths -> final od_out=32767, oc_sat=1; with all inputs -2^15 -> od_out=-32768, oc_sat=1.
REQ-039 SHALL cover channel isolation: impulse on ch1 interleaved with zeros on ch0 -> ch0 outputs all 0, ch1 outputs the impulse response; ic_ch=2 with NCH=2 produces no output.
REQ-040 SHALL cover timing: ic_valid held high continuously -> accepts exactly every 18 cycles (NTAPS=16), oc_valid 18 cycles after each accept.
REQ-041 SHALL cover coefficient access: a write during MAC leaves the result unchanged; a write together with an accept in IDLE is used by that accept.
REQ-042 SHALL cover reset: ic_rst_n pulsed low during cycle 5 of MAC -> no oc_valid, all outputs 0, next impulse response matches a cold start.

Source files
------------

// File: rtl/comp_cic_pkg.sv
// Shared types and width helpers for the compensation FIR.
package comp_cic_pkg;

   // Sequencer states: wait for a sample, run the taps, round the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      ROUND = 2'd2
   } fir_state_e;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int width_f(input int value);
      int r;
      r = clog2_f(value);
      return (r < 1) ? 1 : r;
   endfunction

   // Larger of two integers.
   function automatic int max_f(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/comp_cic_mac_acc.sv
// Signed full-precision multiply-accumulate with synchronous clear and enable.
module comp_cic_mac_acc
   import comp_cic_pkg::*;
#(
   parameter int Win    = 16,
   parameter int Wcoef  = 18,
   parameter int Waccum = 38
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [Win-1:0]    sample,
   input  logic signed [Wcoef-1:0]  coef,
   output logic signed [Waccum-1:0] acc
);

   localparam int WP = Win + Wcoef;

   logic signed [WP-1:0]     sample_ext_s;
   logic signed [WP-1:0]     coef_ext_s;
   logic signed [WP-1:0]     prod_s;
   logic signed [Waccum-1:0] prod_ext_s;
   logic signed [Waccum-1:0] acc_r;

   // Product at full width, then sign-extended to the accumulator width.
   always_comb begin
      sample_ext_s = {{Wcoef{sample[Win-1]}}, sample};
      coef_ext_s   = {{Win{coef[Wcoef-1]}}, coef};
      prod_s       = sample_ext_s * coef_ext_s;
      prod_ext_s   = {{(Waccum-WP){prod_s[WP-1]}}, prod_s};
   end

   // Accumulator: clear wins over enable, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= '0;
      end else if (clr) begin
         acc_r <= '0;
      end else if (en) begin
         acc_r <= acc_r + prod_ext_s;
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/comp_cic_fir.sv
// Multi-channel compensation FIR: one shared coefficient set, per-channel
// circular delay lines, one serial MAC, round/saturate on the way out.
module comp_cic_fir
   import comp_cic_pkg::*;
#(
   parameter int Win    = 16,
   parameter int Wcoef  = 18,
   parameter int Wout   = 16,
   parameter int NTAPS  = 16,
   parameter int NCH    = 2,
   parameter int SHIFT  = 17,
   // derived widths, not meant to be overridden
   parameter int AW     = clog2_f(NTAPS),
   parameter int Waccum = Win + Wcoef + clog2_f(NTAPS),
   parameter int CW     = width_f(NCH)
) (
   input  logic                    clk,
   input  logic                    ic_rst_n,
   input  logic signed [Win-1:0]   id_in,
   input  logic [CW-1:0]           ic_ch,
   input  logic                    ic_valid,
   output logic                    oc_ready,
   input  logic                    ic_coef_we,
   input  logic [AW-1:0]           ic_coef_addr,
   input  logic signed [Wcoef-1:0] id_coef,
   output logic signed [Wout-1:0]  od_out,
   output logic [CW-1:0]           oc_ch,
   output logic                    oc_valid,
   output logic                    oc_sat
);

   localparam int RW  = max_f(Waccum + 1, Wout + 1);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [CW:0]            NCH_C    = (CW+1)'(NCH);
   localparam logic [AW:0]            NTAPS_C  = (AW+1)'(NTAPS);
   localparam logic [AW-1:0]          LAST_TAP = AW'(NTAPS - 1);
   localparam logic signed [RW-1:0]   ONE_C    = {{(RW-1){1'b0}}, 1'b1};
   localparam logic signed [RW-1:0]   RND_C    = (SHIFT > 0) ? (ONE_C << RSH) : {RW{1'b0}};
   localparam logic signed [RW-1:0]   SAT_MAX  = {{(RW-Wout+1){1'b0}}, {(Wout-1){1'b1}}};
   localparam logic signed [RW-1:0]   SAT_MIN  = {{(RW-Wout+1){1'b1}}, {(Wout-1){1'b0}}};

   fir_state_e               state_r;
   fir_state_e               state_s;
   logic                     ready_r;
   logic [AW-1:0]            tap_r;
   logic [AW-1:0]            base_r;
   logic [CW-1:0]            ch_r;
   logic [AW-1:0]            ptr_r [NCH];
   logic signed [Win-1:0]    dl_r [NCH][NTAPS];
   logic signed [Wcoef-1:0]  coef_r [NTAPS];

   logic                     ch_ok_s;
   logic                     accept_s;
   logic                     coef_ok_s;
   logic                     mac_en_s;
   logic [AW:0]              rd_wrap_s;
   logic [AW-1:0]            rd_idx_s;
   logic signed [Win-1:0]    mac_x_s;
   logic signed [Wcoef-1:0]  mac_c_s;
   logic signed [Waccum-1:0] acc_s;

   logic signed [RW-1:0]     rnd_sum_s;
   logic signed [RW-1:0]     rnd_shift_s;
   logic signed [Wout-1:0]   rnd_out_s;
   logic                     rnd_sat_s;

   logic                     fire_r;
   logic signed [Wout-1:0]   res_r;
   logic                     res_sat_r;
   logic [CW-1:0]            res_ch_r;

   // Qualify sample offers and coefficient writes; both only land in IDLE.
   always_comb begin
      ch_ok_s   = ({1'b0, ic_ch} < NCH_C);
      accept_s  = ic_valid & ready_r & ch_ok_s;
      coef_ok_s = ic_coef_we & ready_r & ({1'b0, ic_coef_addr} < NTAPS_C);
      mac_en_s  = (state_r == MAC);
   end

   // Next-state logic for the IDLE -> MAC -> ROUND loop.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = MAC;
            else          state_s = IDLE;
         end
         MAC: begin
            if (tap_r == LAST_TAP) state_s = ROUND;
            else                   state_s = MAC;
         end
         ROUND:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register; ready is registered alongside it so it is glitch-free.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
      end
   end

   assign oc_ready = ready_r;

   // Per-run context: tap counter, newest-sample slot and channel.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         tap_r  <= '0;
         base_r <= '0;
         ch_r   <= '0;
      end else if (accept_s) begin
         tap_r  <= '0;
         base_r <= ptr_r[ic_ch];
         ch_r   <= ic_ch;
      end else if (state_r == MAC) begin
         tap_r  <= (tap_r == LAST_TAP) ? '0 : tap_r + AW'(1);
      end
   end

   // Delay lines: accepted sample overwrites the oldest slot, pointer wraps.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            ptr_r[c] <= '0;
            for (int t = 0; t < NTAPS; t++) begin
               dl_r[c][t] <= '0;
            end
         end
      end else if (accept_s) begin
         dl_r[ic_ch][ptr_r[ic_ch]] <= id_in;
         ptr_r[ic_ch] <= (ptr_r[ic_ch] == LAST_TAP) ? '0 : ptr_r[ic_ch] + AW'(1);
      end
   end

   // Coefficient bank, shared by all channels.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         for (int t = 0; t < NTAPS; t++) begin
            coef_r[t] <= '0;
         end
      end else if (coef_ok_s) begin
         coef_r[ic_coef_addr] <= id_coef;
      end
   end

   // Tap k reads x[n-k]: walk backwards from the newest slot, modulo NTAPS.
   always_comb begin
      rd_wrap_s = '0;
      if (tap_r <= base_r) begin
         rd_idx_s = base_r - tap_r;
      end else begin
         rd_wrap_s = {1'b0, base_r} + NTAPS_C - {1'b0, tap_r};
         rd_idx_s  = rd_wrap_s[AW-1:0];
      end
      mac_x_s = dl_r[ch_r][rd_idx_s];
      mac_c_s = coef_r[tap_r];
   end

   comp_cic_mac_acc #(
      .Win    (Win),
      .Wcoef  (Wcoef),
      .Waccum (Waccum)
   ) u_mac (
      .clk    (clk),
      .rst_n  (ic_rst_n),
      .clr    (accept_s),
      .en     (mac_en_s),
      .sample (mac_x_s),
      .coef   (mac_c_s),
      .acc    (acc_s)
   );

   // Round half-up, arithmetic shift, clip to the output range.
   always_comb begin
      rnd_sum_s   = {{(RW-Waccum){acc_s[Waccum-1]}}, acc_s} + RND_C;
      rnd_shift_s = rnd_sum_s >>> SHIFT;
      if (rnd_shift_s > SAT_MAX) begin
         rnd_out_s = SAT_MAX[Wout-1:0];
         rnd_sat_s = 1'b1;
      end else if (rnd_shift_s < SAT_MIN) begin
         rnd_out_s = SAT_MIN[Wout-1:0];
         rnd_sat_s = 1'b1;
      end else begin
         rnd_out_s = rnd_shift_s[Wout-1:0];
         rnd_sat_s = 1'b0;
      end
   end

   // Capture the rounded result as ROUND ends.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         fire_r    <= 1'b0;
         res_r     <= '0;
         res_sat_r <= 1'b0;
         res_ch_r  <= '0;
      end else begin
         fire_r <= (state_r == ROUND);
         if (state_r == ROUND) begin
            res_r     <= rnd_out_s;
            res_sat_r <= rnd_sat_s;
            res_ch_r  <= ch_r;
         end
      end
   end

   // Publish one cycle later so oc_valid lands NTAPS+2 edges after accept;
   // data outputs hold until the next strobe.
   always_ff @(posedge clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         oc_valid <= 1'b0;
         od_out   <= '0;
         oc_ch    <= '0;
         oc_sat   <= 1'b0;
      end else begin
         oc_valid <= fire_r;
         if (fire_r) begin
            od_out <= res_r;
            oc_ch  <= res_ch_r;
            oc_sat <= res_sat_r;
         end
      end
   end

endmodule
